// File: rtl/trans_addr_pipe_pkg.sv
// Shared definitions for the transpose address delay line: default widths,
// parameter limits and the in-flight counter width derivation.
package trans_addr_pipe_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int N_CH_MAX   = 8;
    localparam int DEPTH_MAX  = 16;

    // Counter must represent 0..depth inclusive.
    function automatic int cnt_w_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/trans_addr_stage.sv
// One pipeline stage of the transpose address delay line: address bundle plus
// write strobe, with clear (highest priority), load and hold.
module trans_addr_stage
    import trans_addr_pipe_pkg::*;
#(
    parameter int W = 2 * ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] addr_in,
    input  logic         wr_in,
    output logic [W-1:0] addr_q,
    output logic         wr_q
);

    logic [W-1:0] addr_d;
    logic         wr_d;

    // Next-state select: clear beats load, otherwise hold.
    always_comb begin
        addr_d = addr_q;
        wr_d   = wr_q;
        if (clear) begin
            addr_d = '0;
            wr_d   = 1'b0;
        end else if (load) begin
            addr_d = addr_in;
            wr_d   = wr_in;
        end else begin
            addr_d = addr_q;
            wr_d   = wr_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wr_q   <= wr_d;
        end
    end

endmodule

// File: rtl/trans_addr_pipe.sv
// Parametrised delay line for transpose-buffer address/write bundles with
// stall, flush, an in-flight write counter and per-channel RAW hazard flags.
module trans_addr_pipe
    import trans_addr_pipe_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int N_CH   = 2,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = cnt_w_f(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [N_CH*ADDR_W-1:0] trans_addr,
    input  logic                   write,
    output logic [N_CH*ADDR_W-1:0] reg_trans_addr,
    output logic                   reg_write,
    output logic [CNT_W-1:0]       in_flight,
    output logic [N_CH-1:0]        hazard
);

    localparam int AW = N_CH * ADDR_W;

    logic [AW-1:0]    addr_in_s [DEPTH];
    logic             wr_in_s   [DEPTH];
    logic [AW-1:0]    addr_s    [DEPTH];
    logic             wr_s      [DEPTH];
    logic             load_s;
    logic [CNT_W-1:0] in_flight_d;
    logic [CNT_W-1:0] in_flight_q;
    logic [N_CH-1:0]  hazard_s;

    assign load_s = ~stall;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign addr_in_s[k] = trans_addr;
            assign wr_in_s[k]   = write;
        end else begin : g_tail
            assign addr_in_s[k] = addr_s[k-1];
            assign wr_in_s[k]   = wr_s[k-1];
        end

        trans_addr_stage #(
            .W (AW)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (load_s),
            .clear   (flush),
            .addr_in (addr_in_s[k]),
            .wr_in   (wr_in_s[k]),
            .addr_q  (addr_s[k]),
            .wr_q    (wr_s[k])
        );
    end

    // Incremental popcount of the stage strobes; enter and exit together cancel.
    always_comb begin
        in_flight_d = in_flight_q;
        if (flush) begin
            in_flight_d = '0;
        end else if (stall) begin
            in_flight_d = in_flight_q;
        end else if (write && !wr_s[DEPTH-1]) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!write && wr_s[DEPTH-1]) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end else begin
            in_flight_d = in_flight_q;
        end
    end

    // In-flight counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    // Per-channel compare of the live input against every stage holding a write.
    always_comb begin
        hazard_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < DEPTH; k++) begin
                hazard_s[c] = hazard_s[c]
                            | (wr_s[k] & (addr_s[k][c*ADDR_W +: ADDR_W]
                                          == trans_addr[c*ADDR_W +: ADDR_W]));
            end
        end
    end

    assign reg_trans_addr = addr_s[DEPTH-1];
    assign reg_write      = wr_s[DEPTH-1];
    assign in_flight      = in_flight_q;
    assign hazard         = hazard_s;

endmodule

// File: tb/tb_trans_addr_pipe.sv
// Self-checking bench for trans_addr_pipe at DEPTH 1, 2 and 3 sharing one stimulus.
module tb_trans_addr_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [19:0] trans_addr;
    logic        write;

    logic [19:0] ra1, ra2, ra3;
    logic        rw1, rw2, rw3;
    logic [0:0]  cnt1;
    logic [1:0]  cnt2, cnt3;
    logic [1:0]  haz1, haz2, haz3;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       write;
        logic [9:0] a1;
        logic [9:0] a0;
        logic [1:0] haz;
        logic       wr;
        logic [9:0] o1;
        logic [9:0] o0;
        logic [1:0] cnt;
    } vec_t;

    vec_t        tbl [19];
    logic [19:0] sb_q [$];
    logic [2:0]  mwr3;
    logic [19:0] last3;

    always #5 clk = ~clk;

    trans_addr_pipe #(.ADDR_W(10), .N_CH(2), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .trans_addr(trans_addr),
        .write(write), .reg_trans_addr(ra1), .reg_write(rw1), .in_flight(cnt1), .hazard(haz1));
    trans_addr_pipe #(.ADDR_W(10), .N_CH(2), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .trans_addr(trans_addr),
        .write(write), .reg_trans_addr(ra2), .reg_write(rw2), .in_flight(cnt2), .hazard(haz2));
    trans_addr_pipe #(.ADDR_W(10), .N_CH(2), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .trans_addr(trans_addr),
        .write(write), .reg_trans_addr(ra3), .reg_write(rw3), .in_flight(cnt3), .hazard(haz3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_rw3", 32'(rw3), 32'd0);
        chk("rst_async_cnt3", 32'(cnt3), 32'd0);
        chk("rst_async_cnt2", 32'(cnt2), 32'd0);
        @(negedge clk);
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        write = 1'b0;
        sb_q.delete();
        mwr3  = 3'b000;
        last3 = 20'h0;
    endtask

    // DEPTH=3 step: scoreboard push on capture, pop when the model says a write is at the output.
    task automatic step3(input logic st, input logic w, input logic [9:0] a);
        logic [19:0] exp_a;
        stall      = st;
        flush      = 1'b0;
        write      = w;
        trans_addr = {a ^ 10'h0F0, a};
        if (!st) begin
            if (w) sb_q.push_back(trans_addr);
            mwr3 = {mwr3[1:0], w};
        end
        @(posedge clk);
        #1;
        chk("d3_reg_write", 32'(rw3), 32'(mwr3[2]));
        chk("d3_in_flight", 32'(cnt3), 32'($countones(mwr3)));
        if (!st && mwr3[2]) begin
            if (sb_q.size() == 0) begin
                chk("d3_sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_a = sb_q.pop_front();
                last3 = exp_a;
                chk("d3_sb_addr", 32'(ra3), 32'(exp_a));
            end
        end else if (st && mwr3[2]) begin
            chk("d3_stall_hold_addr", 32'(ra3), 32'(last3));
        end
        if (!st && w) chk("d3_hazard_own", 32'(haz3), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            st    fl    wr    a1       a0       haz    wr    o1       o0       cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 2'b00, 1'b0, 10'h000, 10'h000, 2'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 2'b11, 1'b1, 10'h3FF, 10'h3FF, 2'd2};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'b00, 1'b1, 10'h3FF, 10'h3FF, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 10'h000, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 10'h055, 10'h011, 2'b00, 1'b0, 10'h000, 10'h000, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'h055, 10'h022, 2'b10, 1'b1, 10'h055, 10'h011, 2'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 10'h055, 10'h022, 2'b10, 1'b0, 10'h055, 10'h022, 2'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 10'h055, 10'h022, 2'b00, 1'b0, 10'h055, 10'h022, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 10'h100, 10'h101, 2'b00, 1'b0, 10'h055, 10'h022, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 10'h102, 10'h103, 2'b00, 1'b1, 10'h100, 10'h101, 2'd2};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 10'h102, 10'h200, 2'b10, 1'b0, 10'h000, 10'h000, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 10'h000, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 10'h000, 2'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 10'h1AA, 10'h1BB, 2'b00, 1'b0, 10'h000, 10'h000, 2'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 10'h2AA, 10'h2BB, 2'b00, 1'b1, 10'h1AA, 10'h1BB, 2'd2};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 10'h3AA, 10'h1BB, 2'b01, 1'b1, 10'h1AA, 10'h1BB, 2'd2};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 10'h2AA, 10'h3BB, 2'b10, 1'b1, 10'h1AA, 10'h1BB, 2'd2};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'b00, 1'b1, 10'h2AA, 10'h2BB, 2'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'b00, 1'b0, 10'h000, 10'h000, 2'd0};

        // Reset held while a write is presented: nothing may enter.
        rst        = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        write      = 1'b1;
        trans_addr = {10'h3FF, 10'h3FF};
        sb_q.delete();
        mwr3       = 3'b000;
        last3      = 20'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_reg_write", 32'(rw2), 32'd0);
        chk("rst_reg_addr", 32'(ra2), 32'd0);
        chk("rst_in_flight", 32'(cnt2), 32'd0);
        chk("rst_hazard", 32'(haz2), 32'd0);
        rst = 1'b1;

        // DEPTH=2 vector table: hazard checked before the edge, outputs after it.
        for (int i = 0; i < 19; i++) begin
            stall      = tbl[i].stall;
            flush      = tbl[i].flush;
            write      = tbl[i].write;
            trans_addr = {tbl[i].a1, tbl[i].a0};
            #1;
            chk($sformatf("tbl%0d_hazard", i), 32'(haz2), 32'(tbl[i].haz));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_reg_write", i), 32'(rw2), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_addr_ch1", i), 32'(ra2[19:10]), 32'(tbl[i].o1));
            chk($sformatf("tbl%0d_addr_ch0", i), 32'(ra2[9:0]), 32'(tbl[i].o0));
            chk($sformatf("tbl%0d_in_flight", i), 32'(cnt2), 32'(tbl[i].cnt));
        end

        // DEPTH=3 streaming with a two-cycle stall mid-stream, then drain.
        do_reset();
        step3(1'b0, 1'b1, 10'd1);
        step3(1'b0, 1'b1, 10'd2);
        step3(1'b0, 1'b1, 10'd3);
        step3(1'b0, 1'b1, 10'd4);
        chk("d3_steady_in_flight", 32'(cnt3), 32'd3);
        step3(1'b1, 1'b1, 10'd5);
        step3(1'b1, 1'b1, 10'd5);
        step3(1'b0, 1'b1, 10'd5);
        step3(1'b0, 1'b1, 10'd6);
        for (int i = 0; i < 4; i++) step3(1'b0, 1'b0, 10'd0);
        chk("d3_sb_drained", 32'(sb_q.size()), 32'd0);

        // DEPTH=1: behaves as one register; alternating then continuous writes.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic        w;
            logic [19:0] a;
            w          = (i < 6) ? 1'(i % 2 == 0) : 1'b1;
            a          = 20'($urandom_range(0, 20'hFFFFF));
            write      = w;
            trans_addr = a;
            @(posedge clk);
            #1;
            chk($sformatf("d1_reg_write_%0d", i), 32'(rw1), 32'(w));
            chk($sformatf("d1_addr_%0d", i), 32'(ra1), 32'(a));
            chk($sformatf("d1_in_flight_%0d", i), 32'(cnt1), 32'(w));
            chk($sformatf("d1_hazard_%0d", i), 32'(haz1), w ? 32'd3 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
